// File: rtl/spike_delay_pkg.sv
// Shared widths, delay type and helper functions for the spike delay line.
package spike_delay_pkg;

  localparam int unsigned MAX_DELAY_DEF = 16;
  localparam int unsigned DLY_W         = $clog2(MAX_DELAY_DEF + 1);

  typedef logic [DLY_W-1:0] delay_t;

  // Width of a delay field able to hold 0..max_delay.
  function automatic int unsigned dly_w(input int unsigned max_delay);
    return (max_delay < 1) ? 1 : $clog2(max_delay + 1);
  endfunction

  // Width of a channel index; a single channel still gets one bit.
  function automatic int unsigned ch_w(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  function automatic int unsigned clamp_delay(input int unsigned d, input int unsigned max_delay);
    return (d > max_delay) ? max_delay : d;
  endfunction

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/spike_delay_line_channel.sv
// One spike channel: history shift register, programmable tap, clear/load.
module spike_delay_channel #(
  parameter int unsigned          MAX_DELAY = 16,
  parameter int unsigned          DELAY_W   = 5,
  parameter logic [DELAY_W-1:0]   RST_DELAY = DELAY_W'(1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spike_i,
  input  logic               flush_i,
  input  logic               load_i,
  input  logic [DELAY_W-1:0] delay_i,
  output logic               tap_o,
  output logic [DELAY_W-1:0] delay_o
);

  logic [MAX_DELAY-1:0] hist_q, hist_d;
  logic [DELAY_W-1:0]   delay_q, delay_d;
  logic                 tap_q, tap_d;

  // The tap is taken from the next history value so the output flop
  // lines up with the history flop holding the spike.
  always_comb begin
    delay_d = delay_q;
    hist_d  = MAX_DELAY'({hist_q, spike_i});
    tap_d   = 1'b0;
    if (load_i) begin
      delay_d = delay_i;
      hist_d  = MAX_DELAY'(spike_i);
    end
    if (flush_i || (delay_d == '0)) hist_d = '0;
    for (int i = 0; i < int'(MAX_DELAY); i++) begin
      if (delay_d == DELAY_W'(i + 1)) tap_d = hist_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q  <= '0;
      delay_q <= RST_DELAY;
      tap_q   <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      delay_q <= delay_d;
      tap_q   <= tap_d;
    end
  end

  assign tap_o   = tap_q;
  assign delay_o = delay_q;

endmodule

// File: rtl/spike_delay_line.sv
// Multi-channel programmable spike delay line with saturating spike counter.
// Optional SPIKE_CLK_GATE_EN turns spike_out into clk-high-phase pulses.
module spike_delay_line
  import spike_delay_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned MAX_DELAY     = 16,
  parameter int unsigned DEFAULT_DELAY = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_CH-1:0]                    spike_in,
  input  logic                               flush,
  input  logic                               cfg_we,
  input  logic [ch_w(N_CH)-1:0]              cfg_ch,
  input  logic [dly_w(MAX_DELAY)-1:0]        cfg_delay,
  output logic [N_CH-1:0]                    spike_out,
  output logic [N_CH*dly_w(MAX_DELAY)-1:0]   delay_rd,
  output logic [CNT_W-1:0]                   spike_cnt
);

  localparam int unsigned DELAY_W = dly_w(MAX_DELAY);
  localparam int unsigned SUM_W   = CNT_W + 1;
  localparam logic [DELAY_W-1:0] RST_DELAY =
    DELAY_W'(clamp_delay(DEFAULT_DELAY, MAX_DELAY));

  logic                 cfg_hit_c;
  logic [DELAY_W-1:0]   cfg_delay_c;
  logic [N_CH-1:0]      tap;
  logic [SUM_W-1:0]     sum_c;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Config decode: out-of-range channels are ignored, oversize delays clamp.
  always_comb begin
    cfg_hit_c   = cfg_we && (32'(cfg_ch) < N_CH);
    cfg_delay_c = DELAY_W'(clamp_delay(32'(cfg_delay), MAX_DELAY));
  end

  for (genvar c = 0; c < int'(N_CH); c++) begin : g_ch
    spike_delay_channel #(
      .MAX_DELAY (MAX_DELAY),
      .DELAY_W   (DELAY_W),
      .RST_DELAY (RST_DELAY)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst),
      .spike_i (spike_in[c]),
      .flush_i (flush),
      .load_i  (cfg_hit_c && (32'(cfg_ch) == c)),
      .delay_i (cfg_delay_c),
      .tap_o   (tap[c]),
      .delay_o (delay_rd[c*DELAY_W +: DELAY_W])
    );
  end

  // Counts the ungated registered taps; one extra bit detects overflow.
  always_comb begin
    sum_c = SUM_W'(cnt_q) + SUM_W'(popcount(64'(tap)));
    cnt_d = sum_c[SUM_W-1] ? '1 : sum_c[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign spike_cnt = cnt_q;

`ifdef SPIKE_CLK_GATE_EN
  assign spike_out = tap & {N_CH{clk}};
`else
  assign spike_out = tap;
`endif

endmodule
